// File: rtl/tdm_demux4.sv
// Four-channel TDM receiver: frame alignment from fsync, MSB-first slot
// assembly, and registered per-channel words with one-cycle valid pulses.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [1:0]       slot_cnt, slot_cnt_n;
  // Only the low WIDTH-1 shifted bits are ever observed, so the MSB is not stored.
  logic [WIDTH-2:0] sh, sh_n;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] ch   [4];
  logic [WIDTH-1:0] ch_n [4];
  logic [3:0]       valid_n;
  logic             done_n, err_n, frame_start;

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    slot_cnt_n  = slot_cnt;
    sh_n        = sh;
    ch_n        = ch;
    valid_n     = '0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    word        = {sh, in};
    frame_start = (bit_cnt == '0) && (slot_cnt == 2'd0);

    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            state_n    = LOCK;
            sh_n       = '0;
            sh_n[0]    = in;
            bit_cnt_n  = CW'(1);
            slot_cnt_n = 2'd0;
          end
        end
        LOCK: begin
          if (fsync && !frame_start) begin
            // Misplaced sync: drop the partial slot and restart the frame on this bit.
            err_n      = 1'b1;
            sh_n       = '0;
            sh_n[0]    = in;
            bit_cnt_n  = CW'(1);
            slot_cnt_n = 2'd0;
          end else if (!fsync && frame_start) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end else begin
            sh_n = word[WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              ch_n[slot_cnt]    = word;
              valid_n[slot_cnt] = 1'b1;
              done_n            = (slot_cnt == 2'd3);
              bit_cnt_n         = '0;
              slot_cnt_n        = slot_cnt + 2'd1;
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      sh         <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) ch[i] <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      slot_cnt   <= slot_cnt_n;
      sh         <= sh_n;
      out_valid  <= valid_n;
      frame_done <= done_n;
      sync_err   <= err_n;
      for (int unsigned i = 0; i < 4; i++) ch[i] <= ch_n[i];
    end
  end

  assign out0   = ch[0];
  assign out1   = ch[1];
  assign out2   = ch[2];
  assign out3   = ch[3];
  assign locked = (state == LOCK);

endmodule
